// File: rtl/inst_pair_queue.sv
// Instruction-pair queue between fetch and decode: a DEPTH-entry FIFO of {pc, first, second}
// with a full-based stall to fetch and flush on redirect. Optional stats: define IQ_STATS_EN.
module inst_pair_queue #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   first_in,
  input  logic [31:0]   second_in,
  output logic          stall,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_first,
  output logic [31:0]   out_second,
  output logic [AW:0]   count
`ifdef IQ_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [15:0]   flush_count
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          enq, deq;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Status decoded from registered occupancy only; out_ready never reaches stall.
  assign stall     = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign enq = in_valid & ~stall & ~flush;
  assign deq = out_valid & out_ready & ~flush;

  assign {out_pc, out_first, out_second} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: reset has priority over flush.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; enq only fires when the slot at wr_ptr is free.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= {pc_in, first_in, second_in};
  end

`ifdef IQ_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall && in_valid) stall_cycles_q <= sat_inc32(stall_cycles_q);
      if (flush)             flush_count_q  <= sat_inc16(flush_count_q);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_inst_pair_queue.sv
// Directed bench for inst_pair_queue with a queue-based scoreboard of accepted pairs.
module tb_inst_pair_queue;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   pc_in = '0, first_in = '0, second_in = '0;
  logic          stall, out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc, out_first, out_second;
  logic [AW:0]   count;
`ifdef IQ_STATS_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   flush_count;
`endif

  int tests = 0;
  int failed = 0;
  logic [95:0] sb[$];

  inst_pair_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .first_in(first_in), .second_in(second_in),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_first(out_first), .out_second(out_second),
    .count(count)
`ifdef IQ_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] f1(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] f2(input logic [31:0] pc);
    return ~pc + 32'h0000_1234;
  endfunction

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic check_model();
    int n = sb.size();
    check_val("count", 96'(count), 96'(n));
    check_val("stall", 96'(stall), 96'(n == DEPTH));
    check_val("out_valid", 96'(out_valid), 96'(n != 0));
    if (n != 0) check_val("head", {out_pc, out_first, out_second}, sb[0]);
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic rdy, input logic fl);
    int  n;
    bit  enq, deq;
    in_valid  = iv;
    pc_in     = pc;
    first_in  = f1(pc);
    second_in = f2(pc);
    out_ready = rdy;
    flush     = fl;
    n   = sb.size();
    enq = iv && (n != DEPTH) && !fl;
    deq = (n != 0) && rdy && !fl;
    @(posedge clock);
    #1;
    if (fl) sb.delete();
    else begin
      if (deq) sb.delete(0);
      if (enq) sb.push_back({pc, f1(pc), f2(pc)});
    end
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    check_model();
  endtask

  initial begin
    // Reset state and empty + out_ready
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to full; fifth pair held
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 8), 1'b0, 1'b0);
    check_val("full_count", 96'(count), 96'(4));
    check_val("full_stall", 96'(stall), 96'(1));
    step(1'b1, 32'h20, 1'b0, 1'b0);
    check_val("held_head", 96'(out_pc), 96'(32'h0));

    // Full + deq, then held pair enters
    step(1'b1, 32'h20, 1'b1, 1'b0);
    check_val("pop_count", 96'(count), 96'(3));
    check_val("pop_stall", 96'(stall), 96'(0));
    step(1'b1, 32'h20, 1'b0, 1'b0);
    check_val("refill_count", 96'(count), 96'(4));

    // Drain to 2, then steady enq+deq
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h28 + 32'(i * 8), 1'b1, 1'b0);
      check_val("steady_count", 96'(count), 96'(2));
    end
    check_val("steady_head", 96'(out_pc), 96'(32'h40));

    // Flush with enq and deq requested
    step(1'b1, 32'h50, 1'b0, 1'b0);
    check_val("pre_flush_count", 96'(count), 96'(3));
    step(1'b1, 32'h58, 1'b1, 1'b1);
    check_val("flush_count0", 96'(count), 96'(0));
    step(1'b1, 32'h60, 1'b0, 1'b0);
    check_val("post_flush_head", 96'(out_pc), 96'(32'h60));

    // Reset while full
    for (int i = 0; i < 3; i++) step(1'b1, 32'h68 + 32'(i * 8), 1'b0, 1'b0);
    check_val("full_again", 96'(stall), 96'(1));
    do_reset();

`ifdef IQ_STATS_EN
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 8), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 32'h200, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("stall_cycles", 96'(stall_cycles), 96'(7));
    check_val("flush_count", 96'(flush_count), 96'(2));
    do_reset();
    check_val("stall_cycles_rst", 96'(stall_cycles), 96'(0));
    check_val("flush_count_rst", 96'(flush_count), 96'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
